// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with threshold flags,
// occupancy count, overflow/underflow pulses and selectable read mode.
// SHOW_AHEAD=0 presents a registered word one cycle after an accepted pull;
// SHOW_AHEAD=1 presents the head word combinationally (zero while empty).
module fifo_sync_param #(
  parameter int DWIDTH     = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2,
  parameter int SHOW_AHEAD = 0,
  localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              push,
  input  logic              pull,
  input  logic [DWIDTH-1:0] d_in,
  output logic [DWIDTH-1:0] d_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_THRESH);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_THRESH);

  // Storage is deliberately left out of reset.
  logic [DWIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;
  logic          unf_q,    unf_d;

  logic pull_acc;
  logic push_acc;

  // Flags come straight from the registered count, never from push/pull.
  always_comb begin
    full         = (count_q == CNT_FULL);
    empty        = (count_q == '0);
    almost_full  = (count_q >= CNT_AF);
    almost_empty = (count_q <= CNT_AE);
    count        = count_q;
    overflow     = ovf_q;
    underflow    = unf_q;
  end

  // Accept logic: a pull frees a slot, so a full FIFO can push while pulling.
  always_comb begin
    pull_acc = pull && !empty;
    push_acc = push && (!full || pull_acc);
  end

  // Next-state: pointers wrap by explicit compare so DEPTH need not be 2^n.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pull_acc) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    unique case ({push_acc, pull_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = push && !push_acc;
    unf_d = pull && !pull_acc;
  end

  // Control state register.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Memory write on accepted push only; rejected pushes leave storage intact.
  always_ff @(posedge sclk) begin
    if (push_acc) mem[wr_ptr_q] <= d_in;
  end

  generate
    if (SHOW_AHEAD != 0) begin : g_fwft
      // Head word is live while non-empty; zero keeps the bus quiet when empty.
      always_comb begin
        d_out = empty ? '0 : mem[rd_ptr_q];
      end
    end else begin : g_reg
      logic [DWIDTH-1:0] dout_q;

      // Registered read: capture the head at the accepted-pull edge, else hold.
      always_ff @(posedge sclk or negedge rst) begin
        if (!rst)          dout_q <= '0;
        else if (pull_acc) dout_q <= mem[rd_ptr_q];
      end

      always_comb begin
        d_out = dout_q;
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench: a default FIFO (16 deep, registered read) and a 5-deep
// show-ahead FIFO share clock and reset; each task owns one scenario.
module tb_fifo_sync_param;

  logic sclk = 1'b0;
  logic rst  = 1'b0;

  logic       m_push = 0, m_pull = 0;
  logic [7:0] m_din = '0, m_dout;
  logic       m_full, m_empty, m_af, m_ae, m_ovf, m_unf;
  logic [4:0] m_cnt;

  logic       s_push = 0, s_pull = 0;
  logic [7:0] s_din = '0, s_dout;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [2:0] s_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sclk = ~sclk;

  fifo_sync_param #(.DWIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .SHOW_AHEAD(0)) dut (
    .sclk(sclk), .rst(rst), .push(m_push), .pull(m_pull), .d_in(m_din), .d_out(m_dout),
    .full(m_full), .empty(m_empty), .almost_full(m_af), .almost_empty(m_ae),
    .count(m_cnt), .overflow(m_ovf), .underflow(m_unf)
  );

  fifo_sync_param #(.DWIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .SHOW_AHEAD(1)) dut_sa (
    .sclk(sclk), .rst(rst), .push(s_push), .pull(s_pull), .d_in(s_din), .d_out(s_dout),
    .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .count(s_cnt), .overflow(s_ovf), .underflow(s_unf)
  );

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    n_tests++;
    if ({m_cnt, m_empty, m_full, m_ae, m_af, m_ovf, m_unf, m_dout} !== {5'd0, 6'b101000, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_main got cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b d=%h exp cnt=0 e=1 f=0 ae=1 af=0 ov=0 un=0 d=00",
               m_cnt, m_empty, m_full, m_ae, m_af, m_ovf, m_unf, m_dout);
    end
    n_tests++;
    if ({s_cnt, s_empty, s_full, s_ae, s_af, s_ovf, s_unf, s_dout} !== {3'd0, 6'b101000, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_sa got cnt=%0d e=%b f=%b d=%h exp cnt=0 e=1 f=0 d=00", s_cnt, s_empty, s_full, s_dout);
    end
    step();
    rst = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      m_push = 1'b1;
      m_din  = 8'(i);
      step();
      n_tests++;
      if (m_cnt !== 5'(i + 1) || m_full !== (i == 15) || m_af !== (i + 1 >= 14) || m_ae !== (i + 1 <= 2)) begin
        n_fail++;
        $display("FAIL fill[%0d] got cnt=%0d f=%b af=%b ae=%b exp cnt=%0d f=%b af=%b ae=%b",
                 i, m_cnt, m_full, m_af, m_ae, i + 1, (i == 15), (i + 1 >= 14), (i + 1 <= 2));
      end
    end
    m_push = 1'b0;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      m_pull = 1'b1;
      step();
      n_tests++;
      if (m_dout !== 8'(i) || m_cnt !== 5'(15 - i)) begin
        n_fail++;
        $display("FAIL drain[%0d] got d=%h cnt=%0d exp d=%h cnt=%0d", i, m_dout, m_cnt, i, 15 - i);
      end
    end
    n_tests++;
    if (m_empty !== 1'b1 || m_unf !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_end got empty=%b unf=%b exp empty=1 unf=0", m_empty, m_unf);
    end
    // One more pull while empty: rejected, pulse, data held.
    step();
    n_tests++;
    if (m_unf !== 1'b1 || m_dout !== 8'h0F || m_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL pull_empty got unf=%b d=%h cnt=%0d exp unf=1 d=0f cnt=0", m_unf, m_dout, m_cnt);
    end
    m_pull = 1'b0;
    step();
    n_tests++;
    if (m_unf !== 1'b0) begin
      n_fail++;
      $display("FAIL unf_pulse got unf=%b exp 0", m_unf);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) begin
      m_push = 1'b1;
      m_din  = 8'(8'h10 + i);
      step();
    end
    m_din = 8'hAA;
    step();
    n_tests++;
    if (m_ovf !== 1'b1 || m_cnt !== 5'd16) begin
      n_fail++;
      $display("FAIL overflow got ovf=%b cnt=%0d exp ovf=1 cnt=16", m_ovf, m_cnt);
    end
    // Full with push and pull together: both accepted, no overflow.
    m_pull = 1'b1;
    m_din  = 8'hBB;
    step();
    n_tests++;
    if (m_ovf !== 1'b0 || m_cnt !== 5'd16 || m_dout !== 8'h10) begin
      n_fail++;
      $display("FAIL full_pushpull got ovf=%b cnt=%0d d=%h exp ovf=0 cnt=16 d=10", m_ovf, m_cnt, m_dout);
    end
    m_push = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      n_tests++;
      if (m_dout !== ((i == 15) ? 8'hBB : 8'(8'h11 + i))) begin
        n_fail++;
        $display("FAIL ovf_drain[%0d] got d=%h exp d=%h", i, m_dout, (i == 15) ? 8'hBB : 8'(8'h11 + i));
      end
    end
    m_pull = 1'b0;
    step();
    n_tests++;
    if (m_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_empty got empty=%b exp 1", m_empty);
    end
  endtask

  task automatic test_underflow_push();
    m_push = 1'b1;
    m_pull = 1'b1;
    m_din  = 8'h55;
    step();
    n_tests++;
    if (m_unf !== 1'b1 || m_cnt !== 5'd1 || m_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_pushpull got unf=%b cnt=%0d empty=%b exp unf=1 cnt=1 empty=0", m_unf, m_cnt, m_empty);
    end
    m_push = 1'b0;
    step();
    n_tests++;
    if (m_dout !== 8'h55 || m_cnt !== 5'd0 || m_unf !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_pushpull_read got d=%h cnt=%0d unf=%b exp d=55 cnt=0 unf=0", m_dout, m_cnt, m_unf);
    end
    m_pull = 1'b0;
    step();
  endtask

  task automatic test_show_ahead();
    logic [1:0] op   [13];
    logic [7:0] din  [13];
    logic [7:0] edout[13];
    logic [2:0] ecnt [13];
    logic       eunf [13];
    // {push,pull}; head word after each edge worked through a 5-entry ring.
    op    = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    din   = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    edout = '{8'hA1, 8'hA1, 8'hA1, 8'hA2, 8'hA3, 8'hA3, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'h00, 8'h00};
    ecnt  = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    eunf  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 13; i++) begin
      s_push = op[i][1];
      s_pull = op[i][0];
      s_din  = din[i];
      step();
      n_tests++;
      if (s_dout !== edout[i] || s_cnt !== ecnt[i] || s_unf !== eunf[i] || s_full !== (ecnt[i] == 3'd5)) begin
        n_fail++;
        $display("FAIL sa[%0d] got d=%h cnt=%0d unf=%b full=%b exp d=%h cnt=%0d unf=%b full=%b",
                 i, s_dout, s_cnt, s_unf, s_full, edout[i], ecnt[i], eunf[i], (ecnt[i] == 3'd5));
      end
    end
    s_push = 1'b0;
    s_pull = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      m_push = 1'b1;
      m_din  = 8'(8'h30 + i);
      step();
    end
    m_push = 1'b0;
    m_pull = 1'b1;
    step();
    m_pull = 1'b0;
    n_tests++;
    if (m_cnt !== 5'd7 || m_dout !== 8'h30) begin
      n_fail++;
      $display("FAIL pre_rst got cnt=%0d d=%h exp cnt=7 d=30", m_cnt, m_dout);
    end
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (m_cnt !== 5'd0 || m_empty !== 1'b1 || m_dout !== 8'h00 || m_ae !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid got cnt=%0d empty=%b d=%h ae=%b exp cnt=0 empty=1 d=00 ae=1", m_cnt, m_empty, m_dout, m_ae);
    end
    #1;
    rst = 1'b1;
    m_push = 1'b1;
    m_din  = 8'h77;
    step();
    m_push = 1'b0;
    m_pull = 1'b1;
    step();
    m_pull = 1'b0;
    n_tests++;
    if (m_dout !== 8'h77 || m_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL post_rst got d=%h cnt=%0d exp d=77 cnt=0", m_dout, m_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_overflow();
    test_underflow_push();
    test_show_ahead();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
